// File: rtl/data_wr_sched_if.sv
// Port bundle between the cache controller / refill engine (master) and the
// data-array port scheduler (slave), including the array-side drive signals.
interface data_wr_sched_if #(
  parameter int INDEX_AW  = 8,
  parameter int OFFSET_AW = 4,
  parameter int DATA_W    = 32
);
  logic                 rd_req_i;
  logic [INDEX_AW-1:0]  rd_index_i;
  logic                 rd_ready_o;
  logic                 rd_valid_o;

  logic                 st_req_i;
  logic [INDEX_AW-1:0]  st_index_i;
  logic [OFFSET_AW-1:0] st_offset_i;
  logic [3:0]           st_wstrb_i;
  logic [DATA_W-1:0]    st_wdata_i;
  logic                 st_ready_o;

  logic                 rf_start_i;
  logic [INDEX_AW-1:0]  rf_index_i;
  logic                 rf_beat_valid_i;
  logic [DATA_W-1:0]    rf_beat_data_i;
  logic                 rf_beat_ready_o;
  logic                 rf_busy_o;
  logic                 rf_done_o;

  logic [INDEX_AW-1:0]  arr_index_o;
  logic [OFFSET_AW-1:0] arr_offset_o;
  logic [3:0]           arr_wr_en_o;
  logic [DATA_W-1:0]    arr_wr_data_o;

  modport master (
    output rd_req_i, rd_index_i,
    output st_req_i, st_index_i, st_offset_i, st_wstrb_i, st_wdata_i,
    output rf_start_i, rf_index_i, rf_beat_valid_i, rf_beat_data_i,
    input  rd_ready_o, rd_valid_o, st_ready_o,
    input  rf_beat_ready_o, rf_busy_o, rf_done_o,
    input  arr_index_o, arr_offset_o, arr_wr_en_o, arr_wr_data_o
  );

  modport slave (
    input  rd_req_i, rd_index_i,
    input  st_req_i, st_index_i, st_offset_i, st_wstrb_i, st_wdata_i,
    input  rf_start_i, rf_index_i, rf_beat_valid_i, rf_beat_data_i,
    output rd_ready_o, rd_valid_o, st_ready_o,
    output rf_beat_ready_o, rf_busy_o, rf_done_o,
    output arr_index_o, arr_offset_o, arr_wr_en_o, arr_wr_data_o
  );
endinterface

// File: rtl/data_wr_sched.sv
// Single-port data-array scheduler: arbitrates loads, store hits and 4-beat
// line refills onto one byte-masked 32-bit array port per cycle.
module data_wr_sched #(
  parameter int INDEX_AW   = 8,
  parameter int OFFSET_AW  = 4,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_wr_sched_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_e;

  state_e              state;
  logic [1:0]          beat_cnt;
  logic [2:0]          starve_cnt;
  logic [INDEX_AW-1:0] rf_index_q;
  logic                rd_valid_q;

  logic port_free;
  logic st_pri;
  logic rd_grant;
  logic st_grant;
  logic beat_acc;

  // Grants are gated by rst so nothing is granted during a reset cycle,
  // even though state only clears at the edge.
  assign port_free = !rst && (state != REFILL);
  assign st_pri    = (starve_cnt >= 3'(STARVE_MAX));
  assign rd_grant  = port_free && bus.rd_req_i && !(bus.st_req_i && st_pri);
  assign st_grant  = port_free && bus.st_req_i && !rd_grant;
  assign beat_acc  = !rst && (state == REFILL) && bus.rf_beat_valid_i;

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    bus.rd_ready_o      = rd_grant;
    bus.st_ready_o      = st_grant;
    bus.rf_beat_ready_o = !rst && (state == REFILL);
    bus.rf_busy_o       = !rst && (state == REFILL);
    bus.rf_done_o       = !rst && (state == DONE);
    bus.rd_valid_o      = rd_valid_q;
    bus.arr_index_o     = bus.rd_index_i;
    bus.arr_offset_o    = '0;
    bus.arr_wr_en_o     = 4'b0000;
    bus.arr_wr_data_o   = bus.st_wdata_i;
    if (state == REFILL) begin
      bus.arr_index_o   = rf_index_q;
      bus.arr_offset_o  = OFFSET_AW'({beat_cnt, 2'b00});
      bus.arr_wr_data_o = DATA_W'(bus.rf_beat_data_i);
      if (beat_acc) bus.arr_wr_en_o = 4'b1111;
    end else if (st_grant) begin
      bus.arr_index_o   = bus.st_index_i;
      bus.arr_offset_o  = bus.st_offset_i;
      bus.arr_wr_en_o   = bus.st_wstrb_i;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= 2'd0;
      starve_cnt <= 3'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_grant;
      unique case (state)
        IDLE: begin
          if (bus.rf_start_i) begin
            state      <= REFILL;
            rf_index_q <= bus.rf_index_i;
            beat_cnt   <= 2'd0;
          end
        end
        REFILL: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 2'd1;
            if (beat_cnt == 2'd3) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Starvation is only tracked while the port is contestable.
      if (state != REFILL) begin
        if (st_grant || !bus.st_req_i) begin
          starve_cnt <= 3'd0;
        end else if (starve_cnt < 3'(STARVE_MAX)) begin
          starve_cnt <= starve_cnt + 3'd1;
        end
      end
    end
  end

  // NOTE: rf_index_q is a pure datapath register qualified by state, so it has no reset.

endmodule

// File: doc/data_wr_sched.md
# data_wr_sched

Port scheduler for the single-ported cache data array, which has four 32-bit banks per line, one shared index, and one 32-bit byte-masked write per cycle. It shares that port between three requesters: CPU load reads, CPU store-hit writes, and line refills. A refill is sequenced as four 32-bit beats written to banks 0..3. The block sits between the cache control FSM/refill engine and the data array instance of each way.

## Interface
- INDEX_AW, 8, index width (line select)
- OFFSET_AW, 4, byte offset width; bits [3:2] select the bank
- DATA_W, 32, write data width per beat
- STARVE_MAX, 4, consecutive lost store cycles before the store gets priority over reads
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- rd_req_i  input  1  load read request
- rd_index_i  input  INDEX_AW  load index
- rd_ready_o  output  1  read granted this cycle
- rd_valid_o  output  1  array read data valid; registered one cycle after the grant
- st_req_i  input  1  store-hit write request
- st_index_i  input  INDEX_AW  store index
- st_offset_i  input  OFFSET_AW  store offset
- st_wstrb_i  input  4  store byte strobes
- st_wdata_i  input  DATA_W  store data
- st_ready_o  output  1  store granted this cycle
- rf_start_i  input  1  begin refill of line rf_index_i
- rf_index_i  input  INDEX_AW  refill index; sampled at start
- rf_beat_valid_i  input  1  refill beat available
- rf_beat_data_i  input  DATA_W  refill beat data, in order bank 0..3
- rf_beat_ready_o  output  1  beat accepted this cycle
- rf_busy_o  output  1  refill in progress
- rf_done_o  output  1  one-cycle pulse after the 4th beat is written
- arr_index_o  output  INDEX_AW  to data array index
- arr_offset_o  output  OFFSET_AW  to data array offset
- arr_wr_en_o  output  4  to data array byte write enables
- arr_wr_data_o  output  DATA_W  to data array write data

## Operation
- FSM states:
  - IDLE -> REFILL when rf_start_i=1 in IDLE. That cycle latches rf_index_i, clears beat_cnt and sets busy.
  - REFILL -> DONE when a beat is accepted with beat_cnt=3.
  - DONE -> IDLE unconditionally. rf_done_o=1 only in DONE.
- REFILL owns the port exclusively:
  - rf_beat_ready_o=1 in REFILL; rd_ready_o=0 and st_ready_o=0.
  - On rf_beat_valid_i=1: index=latched index, offset={beat_cnt,2'b00}, wr_en=4'b1111, wr_data=rf_beat_data_i.
  - beat_cnt (2 bits) increments on each accepted beat and wraps 3->0.
  - When rf_beat_valid_i=0, arr_wr_en_o=0 and beat_cnt holds.
- IDLE and DONE: the port is free to rd/st, including the rf_start_i cycle.
  - Default priority: read over store.
  - If starve_cnt>=STARVE_MAX and both request, the store wins.
- Read grant:
  - arr_index_o=rd_index_i, arr_wr_en_o=0.
  - rd_valid_o=1 on the next cycle; the array data is then on its rd_data_o.
- Store grant:
  - arr_index_o=st_index_i, arr_offset_o=st_offset_i, arr_wr_en_o=st_wstrb_i, arr_wr_data_o=st_wdata_i.
  - A store with st_wstrb_i=0 is still granted; it performs no write.
- starve_cnt (3 bits, saturating at STARVE_MAX):
  - Increments when st_req_i=1 and the store is not granted in IDLE/DONE.
  - Holds during REFILL.
  - Clears on a store grant, or on st_req_i=0.
- rf_start_i in REFILL or DONE is ignored. The refill engine must wait for rf_busy_o=0.
- With no grant, arr_wr_en_o=0 and arr_index_o/arr_offset_o are don't-care (driven from the read inputs).

## Timing
- Grants are combinational from the requests and current state. A transfer completes at the rising edge where req&ready=1. The array write occurs at that same edge.
- Refill, zero-stall case:
  - Start at edge 0.
  - Beats written at edges 1–4.
  - rf_done_o high in the cycle after edge 4.
  - rf_busy_o low from DONE onward. rf_busy_o=1 in REFILL only.
- Reset (rst=1 at an edge): state=IDLE, beat_cnt=0, starve_cnt=0, rd_valid_o=0.
  - While rst=1 all ready outputs, rf_busy_o, rf_done_o and arr_wr_en_o are 0.
  - Reset mid-refill aborts it: no further beats, no rf_done_o.

## Test plan
- Reset: hold rst 2 cycles with all requests high -> every ready output 0, arr_wr_en_o=0, rf_done_o=0; after release, a read is granted first.
- Refill: start index 0x3A, beats 0x11111111..0x44444444 with an invalid gap before beat 2 -> writes at offsets 0x0/0x4/0x8/0xC with wr_en 4'hF; rf_done_o pulses once, 1 cycle after the 4th write.
- Contention during refill: rd_req_i and st_req_i held high throughout -> no grants while rf_busy_o=1; the read is granted in the DONE cycle.
- Starvation: st_req_i and rd_req_i held high continuously, STARVE_MAX=4 -> 4 read grants, then a store grant on the 5th cycle, then reads resume.
- Store path: index 0x05, offset 0x6, wstrb 4'b1100, data 0xAABBCCDD -> arr_offset_o=0x6, arr_wr_en_o=4'b1100 for exactly one cycle; a read of 0x05 next cycle shows bank 1 bytes 3:2=0xAABB.
- Abort: assert rst after 2 refill beats -> no rf_done_o; a new rf_start_i then writes from bank 0.
